lsu_align_ctrl: RTL and testbench

- Load/store unit in the MEM stage, directly upstream of the byte-addressed data memory.
- Aligned accesses pass through to memory combinationally with zero latency.
- Misaligned halfword and word accesses are split into sequential byte accesses under an FSM while the pipeline is stalled.
- Load bytes are reassembled and sign- or zero-extended before returning to the MEM/WB path.

---
 rtl/lsu_align_ctrl.sv | 142 ++++++++++++++
 tb/tb_lsu_align_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_ctrl.sv
// MEM-stage load/store aligner: aligned accesses pass straight to the byte-addressed
// data memory, misaligned halfword/word accesses are split into byte operations.
module lsu_align_ctrl #(
   parameter int ADDR_W   = 32,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              mem_read_write,
   output logic [2:0]        mem_access_size,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_data_in,
   input  logic [31:0]       mem_rdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              misalign_err
);

   typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic              latch_req;
   logic [ADDR_W-1:0] lat_addr;
   logic [2:0]        lat_funct3;
   logic              lat_we;
   logic [31:0]       lat_wdata;
   logic [2:0]        byte_cnt;
   logic [2:0]        byte_idx;
   logic [31:0]       rd_buf;
   logic              legal;
   logic              misaligned;

   assign legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b101);

   // Halfword codes share funct3[1:0]=01; bytes can never be misaligned.
   assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));

   always_ff @(posedge clock) begin
      if (!reset) begin
         state      <= IDLE;
         lat_addr   <= '0;
         lat_funct3 <= 3'b000;
         lat_we     <= 1'b0;
         lat_wdata  <= '0;
         byte_cnt   <= '0;
         byte_idx   <= '0;
         rd_buf     <= '0;
      end else begin
         state <= next_state;
         if (latch_req) begin
            lat_addr   <= req_addr;
            lat_funct3 <= req_funct3;
            lat_we     <= req_we;
            lat_wdata  <= req_wdata;
            byte_cnt   <= (req_funct3 == 3'b010) ? 3'd4 : 3'd2;
            byte_idx   <= '0;
         end else if (state == SPLIT) begin
            byte_idx <= byte_idx + 3'd1;
            if (!lat_we)
               rd_buf[{byte_idx[1:0], 3'b000} +: 8] <= mem_rdata[7:0];
         end
      end
   end

   always_comb begin
      next_state      = state;
      latch_req       = 1'b0;
      mem_read_write  = 1'b0;
      mem_access_size = 3'b010;
      mem_address     = '0;
      mem_data_in     = '0;
      stall           = 1'b0;
      resp_valid      = 1'b0;
      resp_rdata      = '0;
      misalign_err    = 1'b0;
      // Everything stays at idle drive while reset is held low.
      if (reset) begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (!legal) begin
                     resp_valid = !req_we;
                  end else if (misaligned) begin
                     if (SPLIT_EN) begin
                        stall      = 1'b1;
                        latch_req  = 1'b1;
                        next_state = SPLIT;
                     end else begin
                        misalign_err = 1'b1;
                        resp_valid   = !req_we;
                     end
                  end else begin
                     mem_read_write  = req_we;
                     mem_access_size = req_funct3;
                     mem_address     = req_addr;
                     mem_data_in     = req_wdata;
                     if (!req_we) begin
                        resp_valid = 1'b1;
                        resp_rdata = mem_rdata;
                     end
                  end
               end
            end
            SPLIT: begin
               stall       = 1'b1;
               mem_address = lat_addr + ADDR_W'(byte_idx);
               if (lat_we) begin
                  mem_read_write   = 1'b1;
                  mem_access_size  = 3'b000;
                  mem_data_in[7:0] = lat_wdata[{byte_idx[1:0], 3'b000} +: 8];
               end else begin
                  mem_access_size = 3'b100;
               end
               if (byte_idx == byte_cnt - 3'd1)
                  next_state = DONE;
            end
            DONE: begin
               resp_valid = !lat_we;
               if (!lat_we) begin
                  case (lat_funct3)
                     3'b001:  resp_rdata = {{16{rd_buf[15]}}, rd_buf[15:0]};
                     3'b101:  resp_rdata = {16'h0000, rd_buf[15:0]};
                     default: resp_rdata = rd_buf;
                  endcase
               end
               next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Directed bench for lsu_align_ctrl: one split-enabled and one split-disabled instance,
// each attached to its own byte-addressed memory model.
module tb_lsu_align_ctrl;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rw_a, stall_a, rv_a, err_a;
   logic [2:0]  size_a;
   logic [31:0] addr_a, din_a, rdata_a, resp_a;
   logic        rw_b, stall_b, rv_b, err_b;
   logic [2:0]  size_b;
   logic [31:0] addr_b, din_b, rdata_b, resp_b;

   logic [7:0]  mem_a [0:1023];
   logic [7:0]  mem_b [0:1023];

   int checks = 0;
   int errors = 0;

   lsu_align_ctrl #(.ADDR_W(32), .SPLIT_EN(1'b1)) u_dut_a (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_read_write(rw_a), .mem_access_size(size_a), .mem_address(addr_a),
      .mem_data_in(din_a), .mem_rdata(rdata_a), .stall(stall_a),
      .resp_valid(rv_a), .resp_rdata(resp_a), .misalign_err(err_a)
   );

   lsu_align_ctrl #(.ADDR_W(32), .SPLIT_EN(1'b0)) u_dut_b (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_read_write(rw_b), .mem_access_size(size_b), .mem_address(addr_b),
      .mem_data_in(din_b), .mem_rdata(rdata_b), .stall(stall_b),
      .resp_valid(rv_b), .resp_rdata(resp_b), .misalign_err(err_b)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_extend(input logic [2:0] sz, input logic [7:0] b0,
                                              input logic [7:0] b1, input logic [7:0] b2,
                                              input logic [7:0] b3);
      case (sz)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b100:  return {24'h0, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   assign rdata_a = mem_extend(size_a, mem_a[addr_a[9:0]], mem_a[addr_a[9:0] + 10'd1],
                               mem_a[addr_a[9:0] + 10'd2], mem_a[addr_a[9:0] + 10'd3]);
   assign rdata_b = mem_extend(size_b, mem_b[addr_b[9:0]], mem_b[addr_b[9:0] + 10'd1],
                               mem_b[addr_b[9:0] + 10'd2], mem_b[addr_b[9:0] + 10'd3]);

   // Memory writes land on the rising edge, sized by the access encoding.
   always @(posedge clock) begin
      if (rw_a) begin
         mem_a[addr_a[9:0]] = din_a[7:0];
         if (size_a[1:0] != 2'b00) mem_a[addr_a[9:0] + 10'd1] = din_a[15:8];
         if (size_a[1:0] == 2'b10) begin
            mem_a[addr_a[9:0] + 10'd2] = din_a[23:16];
            mem_a[addr_a[9:0] + 10'd3] = din_a[31:24];
         end
      end
      if (rw_b) begin
         mem_b[addr_b[9:0]] = din_b[7:0];
         if (size_b[1:0] != 2'b00) mem_b[addr_b[9:0] + 10'd1] = din_b[15:8];
         if (size_b[1:0] == 2'b10) begin
            mem_b[addr_b[9:0] + 10'd2] = din_b[23:16];
            mem_b[addr_b[9:0] + 10'd3] = din_b[31:24];
         end
      end
   end

   task automatic preload();
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 8'h00;
         mem_b[i] = 8'h00;
      end
      for (int i = 0; i < 9; i++) begin
         mem_a[10'h100 + i] = 8'h11 * (i + 1);
         mem_b[10'h100 + i] = 8'h11 * (i + 1);
      end
   endtask

   // Drives a request at a falling edge, then holds it until stall drops (bounded).
   task automatic issue_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output int stalls,
                            output logic done_valid, output logic [31:0] done_rdata);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      #1;
      stalls = 0;
      while (stall_a === 1'b1 && stalls < 20) begin
         stalls++;
         @(negedge clock);
         #1;
      end
      done_valid = rv_a;
      done_rdata = resp_a;
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = '0;
      req_wdata  = '0;
      @(negedge clock);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h100;
      req_wdata = 32'hCAFEF00D;
      #1;
      checks++; if (rw_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_rw: got %b want 0", rw_a); end
      checks++; if (stall_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b want 0", stall_a); end
      checks++; if (size_a !== 3'b010) begin errors++; $display("[TB] FAIL reset_size: got %b want 010", size_a); end
      checks++; if (addr_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h want 0", addr_a); end
      checks++; if (din_a !== 32'h0) begin errors++; $display("[TB] FAIL reset_din: got %h want 0", din_a); end
      @(negedge clock);
      reset     = 1'b1;
      req_valid = 1'b0;
      #1;
      checks++; if (mem_a[10'h100] !== 8'h11) begin errors++; $display("[TB] FAIL reset_nowrite: got %h want 11", mem_a[10'h100]); end
      checks++; if (rv_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_resp_valid: got %b want 0", rv_a); end
      @(negedge clock);
   endtask

   task automatic test_aligned_lw();
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h100;
      #1;
      checks++; if (stall_a !== 1'b0) begin errors++; $display("[TB] FAIL alw_stall: got %b want 0", stall_a); end
      checks++; if (rv_a !== 1'b1) begin errors++; $display("[TB] FAIL alw_valid: got %b want 1", rv_a); end
      checks++; if (resp_a !== 32'h44332211) begin errors++; $display("[TB] FAIL alw_rdata: got %h want 44332211", resp_a); end
      checks++; if (size_a !== 3'b010) begin errors++; $display("[TB] FAIL alw_size: got %b want 010", size_a); end
      checks++; if (addr_a !== 32'h100) begin errors++; $display("[TB] FAIL alw_addr: got %h want 100", addr_a); end
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic test_misaligned_lw();
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h101;
      #1;
      checks++; if (stall_a !== 1'b1) begin errors++; $display("[TB] FAIL mlw_stall0: got %b want 1", stall_a); end
      checks++; if (addr_a !== 32'h0) begin errors++; $display("[TB] FAIL mlw_idle_addr: got %h want 0", addr_a); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         #1;
         checks++; if (stall_a !== 1'b1) begin errors++; $display("[TB] FAIL mlw_stall k=%0d: got %b want 1", k, stall_a); end
         checks++; if (addr_a !== 32'h101 + k) begin errors++; $display("[TB] FAIL mlw_addr k=%0d: got %h want %h", k, addr_a, 32'h101 + k); end
         checks++; if (size_a !== 3'b100 || rw_a !== 1'b0) begin errors++; $display("[TB] FAIL mlw_size k=%0d: got %b/%b want 100/0", k, size_a, rw_a); end
      end
      @(negedge clock);
      #1;
      checks++; if (stall_a !== 1'b0) begin errors++; $display("[TB] FAIL mlw_done_stall: got %b want 0", stall_a); end
      checks++; if (rv_a !== 1'b1) begin errors++; $display("[TB] FAIL mlw_done_valid: got %b want 1", rv_a); end
      checks++; if (resp_a !== 32'h55443322) begin errors++; $display("[TB] FAIL mlw_rdata: got %h want 55443322", resp_a); end
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic test_misaligned_half();
      int          stalls;
      logic        valid;
      logic [31:0] rdata;
      issue_req(1'b0, 3'b001, 32'h107, 32'h0, stalls, valid, rdata);
      checks++; if (stalls != 3) begin errors++; $display("[TB] FAIL lh_stalls: got %0d want 3", stalls); end
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL lh_valid: got %b want 1", valid); end
      checks++; if (rdata !== 32'hFFFF9988) begin errors++; $display("[TB] FAIL lh_rdata: got %h want FFFF9988", rdata); end
      issue_req(1'b0, 3'b101, 32'h107, 32'h0, stalls, valid, rdata);
      checks++; if (stalls != 3) begin errors++; $display("[TB] FAIL lhu_stalls: got %0d want 3", stalls); end
      checks++; if (rdata !== 32'h00009988) begin errors++; $display("[TB] FAIL lhu_rdata: got %h want 00009988", rdata); end
   endtask

   task automatic test_misaligned_sw();
      int          stalls;
      logic        valid;
      logic [31:0] rdata;
      issue_req(1'b1, 3'b010, 32'h102, 32'hDEADBEEF, stalls, valid, rdata);
      checks++; if (stalls != 5) begin errors++; $display("[TB] FAIL sw_stalls: got %0d want 5", stalls); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL sw_valid: got %b want 0", valid); end
      checks++; if (mem_a[10'h102] !== 8'hEF) begin errors++; $display("[TB] FAIL sw_b102: got %h want EF", mem_a[10'h102]); end
      checks++; if (mem_a[10'h103] !== 8'hBE) begin errors++; $display("[TB] FAIL sw_b103: got %h want BE", mem_a[10'h103]); end
      checks++; if (mem_a[10'h104] !== 8'hAD) begin errors++; $display("[TB] FAIL sw_b104: got %h want AD", mem_a[10'h104]); end
      checks++; if (mem_a[10'h105] !== 8'hDE) begin errors++; $display("[TB] FAIL sw_b105: got %h want DE", mem_a[10'h105]); end
      issue_req(1'b0, 3'b010, 32'h104, 32'h0, stalls, valid, rdata);
      checks++; if (stalls != 0) begin errors++; $display("[TB] FAIL sw_lw_stalls: got %0d want 0", stalls); end
      checks++; if (rdata !== 32'h8877DEAD) begin errors++; $display("[TB] FAIL sw_lw_rdata: got %h want 8877DEAD", rdata); end
   endtask

   task automatic test_reset_in_split();
      preload();
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h102;
      req_wdata  = 32'hDEADBEEF;
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++; if (rw_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_split_rw: got %b want 0", rw_a); end
      checks++; if (stall_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_split_stall: got %b want 0", stall_a); end
      @(negedge clock);
      reset     = 1'b1;
      req_valid = 1'b0;
      #1;
      checks++; if (stall_a !== 1'b0 || addr_a !== 32'h0) begin errors++; $display("[TB] FAIL rst_idle: got stall %b addr %h want 0/0", stall_a, addr_a); end
      checks++; if (mem_a[10'h102] !== 8'hEF) begin errors++; $display("[TB] FAIL rst_b102: got %h want EF", mem_a[10'h102]); end
      checks++; if (mem_a[10'h103] !== 8'hBE) begin errors++; $display("[TB] FAIL rst_b103: got %h want BE", mem_a[10'h103]); end
      checks++; if (mem_a[10'h104] !== 8'h55) begin errors++; $display("[TB] FAIL rst_b104: got %h want 55", mem_a[10'h104]); end
      checks++; if (mem_a[10'h105] !== 8'h66) begin errors++; $display("[TB] FAIL rst_b105: got %h want 66", mem_a[10'h105]); end
      @(negedge clock);
      #1;
      checks++; if (stall_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_stall: got %b want 0", stall_a); end
      @(negedge clock);
   endtask

   task automatic test_no_split();
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h101;
      #1;
      checks++; if (err_b !== 1'b1) begin errors++; $display("[TB] FAIL ns_lw_err: got %b want 1", err_b); end
      checks++; if (rv_b !== 1'b1 || resp_b !== 32'h0) begin errors++; $display("[TB] FAIL ns_lw_resp: got %b/%h want 1/0", rv_b, resp_b); end
      checks++; if (stall_b !== 1'b0) begin errors++; $display("[TB] FAIL ns_lw_stall: got %b want 0", stall_b); end
      @(negedge clock);
      req_we     = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 32'h101;
      req_wdata  = 32'h0000ABCD;
      #1;
      checks++; if (err_b !== 1'b1) begin errors++; $display("[TB] FAIL ns_sh_err: got %b want 1", err_b); end
      checks++; if (rw_b !== 1'b0) begin errors++; $display("[TB] FAIL ns_sh_rw: got %b want 0", rw_b); end
      @(negedge clock);
      req_funct3 = 3'b011;
      req_addr   = 32'h100;
      req_wdata  = 32'h12345678;
      #1;
      checks++; if (mem_b[10'h101] !== 8'h22 || mem_b[10'h102] !== 8'h33) begin errors++; $display("[TB] FAIL ns_sh_mem: got %h %h want 22 33", mem_b[10'h101], mem_b[10'h102]); end
      checks++; if (rw_b !== 1'b0) begin errors++; $display("[TB] FAIL ill_rw: got %b want 0", rw_b); end
      checks++; if (err_b !== 1'b0 || rv_b !== 1'b0) begin errors++; $display("[TB] FAIL ill_flags: got err %b valid %b want 0/0", err_b, rv_b); end
      @(negedge clock);
      req_valid = 1'b0;
      #1;
      checks++; if (mem_b[10'h100] !== 8'h11) begin errors++; $display("[TB] FAIL ill_mem: got %h want 11", mem_b[10'h100]); end
      @(negedge clock);
   endtask

   initial begin
      preload();
      test_reset();
      test_aligned_lw();
      test_misaligned_lw();
      test_misaligned_half();
      test_misaligned_sw();
      test_reset_in_split();
      preload();
      test_no_split();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
